// File: rtl/poly_small_pkg.sv
// Shared constants and types for the Falcon small-poly (f,g) norm checker.
package poly_small_pkg;

  localparam int LOGN       = 9;
  localparam int N          = 1 << LOGN;
  localparam int ACC_W      = 24;
  localparam int NORM_BOUND = 16823;

  typedef enum logic [2:0] {
    IDLE,
    RUN_F,
    GAP,
    RUN_G,
    CHECK,
    DONE
  } state_t;

  typedef logic signed [7:0] coef_t;

endpackage

// File: rtl/poly_small_buf.sv
// Coefficient store for f (lower half) and g (upper half).
// One write port, one read port with a registered output (1-cycle latency).
module poly_small_buf
  import poly_small_pkg::*;
#(
  parameter int AW = poly_small_pkg::LOGN + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  coef_t         wdata,
  input  logic [AW-1:0] raddr,
  output coef_t         rdata
);

  coef_t r_mem [0:(1<<AW)-1];
  coef_t r_rdata;

  // Write port: the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/poly_small_fg_norm.sv
// Collects f then g from the small-poly Gaussian sampler, stores them, and
// accumulates ||(f,g)||^2 for the accept/reject decision against NORM_BOUND.
// Optional build macro NORM_EARLY_ABORT_EN: stop sampling as soon as the
// result is known to be a reject (bound reached or a -128 coefficient).
module poly_small_fg_norm #(
  parameter int LOGN       = poly_small_pkg::LOGN,
  parameter int ACC_W      = poly_small_pkg::ACC_W,
  parameter int NORM_BOUND = poly_small_pkg::NORM_BOUND
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             sampler_ena,
  input  logic             f_valid,
  input  logic [7:0]       f,
  output logic             busy,
  output logic             done,
  output logic             accept,
  output logic [ACC_W-1:0] norm_sq,
  input  logic [LOGN:0]    rd_addr,
  output logic [7:0]       rd_data
);

  import poly_small_pkg::*;

  state_t           r_state, w_state_next;
  logic [LOGN-1:0]  r_idx;
  logic [ACC_W-1:0] r_acc;
  logic             r_bad_range;
  logic             r_accept;
  logic             r_done;
  logic [ACC_W-1:0] r_norm_sq;

  logic             w_run;
  logic             w_take;
  logic             w_start_ok;
  logic             w_last;
  logic             w_is_min;
  logic             w_abort;
  logic signed [15:0] w_ext;
  logic [15:0]      w_sq;
  logic [ACC_W:0]   w_sum_wide;
  logic [ACC_W-1:0] w_acc_sum;
  coef_t            w_rdata;

  assign w_run      = (r_state == RUN_F) || (r_state == RUN_G);
  assign w_take     = w_run && f_valid;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = &r_idx;
  assign w_is_min   = (f == 8'h80);

  // Square of a sign-extended coefficient; at most 128^2 = 16384, fits 16 bits.
  assign w_ext      = {{8{f[7]}}, f};
  assign w_sq       = w_ext * w_ext;
  assign w_sum_wide = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, w_sq};
  assign w_acc_sum  = w_sum_wide[ACC_W] ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];

`ifdef NORM_EARLY_ABORT_EN
  assign w_abort = w_take && ((w_acc_sum >= ACC_W'(NORM_BOUND)) || w_is_min);
`else
  assign w_abort = 1'b0;
`endif

  // Next-state logic for the f / gap / g / check sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_state_next = RUN_F;
      RUN_F: begin
        if (w_abort)              w_state_next = CHECK;
        else if (w_take && w_last) w_state_next = GAP;
      end
      GAP:   w_state_next = RUN_G;
      RUN_G: begin
        if (w_abort || (w_take && w_last)) w_state_next = CHECK;
      end
      CHECK: w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, index, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_bad_range <= 1'b0;
      r_accept    <= 1'b0;
      r_done      <= 1'b0;
      r_norm_sq   <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == CHECK);
      if (w_start_ok) begin
        r_acc       <= '0;
        r_bad_range <= 1'b0;
        r_idx       <= '0;
        r_accept    <= 1'b0;
      end else if (w_take) begin
        r_acc       <= w_acc_sum;
        r_bad_range <= r_bad_range | w_is_min;
        r_idx       <= r_idx + 1'b1;
      end else if (r_state == GAP) begin
        r_idx <= '0;
      end
      if (r_state == CHECK) begin
        r_accept  <= !r_bad_range && (r_acc < ACC_W'(NORM_BOUND));
        r_norm_sq <= r_acc;
      end
    end
  end

  poly_small_buf #(
    .AW (LOGN + 1)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (w_take),
    .waddr ({r_state == RUN_G, r_idx}),
    .wdata (coef_t'(f)),
    .raddr (rd_addr),
    .rdata (w_rdata)
  );

  assign sampler_ena = w_run;
  assign busy        = w_run || (r_state == GAP) || (r_state == CHECK);
  assign done        = r_done;
  assign accept      = r_accept;
  assign norm_sq     = r_norm_sq;
  assign rd_data     = w_rdata;

endmodule

// File: tb/tb_poly_small_fg_norm.sv
// Directed bench for poly_small_fg_norm. Plays the role of the Gaussian
// sampler, then checks done timing, accept, norm_sq and buffer readback.
// Also exercises the NORM_EARLY_ABORT_EN build when that macro is defined.
module tb_poly_small_fg_norm;

  localparam int LOGN = 9;
  localparam int N    = 1 << LOGN;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sampler_ena;
  logic        f_valid;
  logic [7:0]  f;
  logic        busy;
  logic        done;
  logic        accept;
  logic [23:0] norm_sq;
  logic [LOGN:0] rd_addr;
  logic [7:0]  rd_data;

  int   checks   = 0;
  int   failures = 0;
  bit   gaps     = 1'b0;
  logic [7:0] coef [0:2*N-1];

  poly_small_fg_norm dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sampler_ena (sampler_ena),
    .f_valid     (f_valid),
    .f           (f),
    .busy        (busy),
    .done        (done),
    .accept      (accept),
    .norm_sq     (norm_sq),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_coef();
    for (int i = 0; i < 2*N; i++) coef[i] = 8'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present coef[0..cnt-1] while sampler_ena is high, optionally with idle gaps.
  task automatic feed(input int cnt, input string tag);
    int low;
    for (int i = 0; i < cnt; i++) begin
      low = 0;
      while (!sampler_ena && low < 20) begin
        tick();
        low++;
      end
      if (i == N) chk({tag, "_ena_low_cycles"}, low, 1);
      if (low >= 20) chk({tag, "_ena_timeout"}, {31'd0, sampler_ena}, 1);
      if (gaps) repeat ($urandom_range(0, 4)) tick();
      f_valid = 1'b1;
      f       = coef[i];
      tick();
      f_valid = 1'b0;
      $display("feed %s coef %0d = %0d", tag, i, $signed(coef[i]));
    end
  endtask

  // Called just after the edge that captured the last coefficient; done must
  // be seen two cycles after that coefficient was presented.
  task automatic wait_done(input string tag);
    int lat;
    lat = 1;
    while (!done && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_done_latency"}, lat, 2);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    $display("done %s accept=%0d norm_sq=%0d", tag, accept, norm_sq);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = (LOGN+1)'(addr);
    tick();
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic load_test2();
    clear_coef();
    coef[0] = 8'd127;
    coef[1] = 8'd26;
    coef[2] = 8'd4;
    coef[3] = 8'd1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; f_valid = 1'b0; f = 8'd0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_sampler_ena", {31'd0, sampler_ena}, 0);
    chk("rst_busy",        {31'd0, busy}, 0);
    chk("rst_done",        {31'd0, done}, 0);
    chk("rst_accept",      {31'd0, accept}, 0);
    chk("rst_norm_sq",     {8'd0, norm_sq}, 0);
    chk("rst_rd_data",     {24'd0, rd_data}, 0);
    rst = 1'b0;
    tick();

    // Test 1: f[0]=1, g[0]=1 -> norm 2, accept
    clear_coef();
    coef[0] = 8'd1;
    coef[N] = 8'd1;
    do_start();
    chk("t1_busy", {31'd0, busy}, 1);
    feed(2*N, "t1");
    wait_done("t1");
    chk("t1_accept",  {31'd0, accept}, 1);
    chk("t1_norm_sq", {8'd0, norm_sq}, 2);
    read_chk("t1_rd_f0", 0, 8'd1);
    read_chk("t1_rd_g0", N, 8'd1);
    read_chk("t1_rd_f1", 1, 8'd0);

    // Test 2: 127^2+26^2+4^2+1 = 16822, just under the bound
    load_test2();
    do_start();
    chk("t2_accept_cleared", {31'd0, accept}, 0);
    feed(2*N, "t2");
    wait_done("t2");
    chk("t2_accept",  {31'd0, accept}, 1);
    chk("t2_norm_sq", {8'd0, norm_sq}, 16822);
    read_chk("t2_rd_f1", 1, 8'd26);
    read_chk("t2_rd_f3", 3, 8'd1);
    read_chk("t2_rd_g0", N, 8'd0);

    // Test 2b: add g[0]=1 -> exactly the bound, reject
    coef[N] = 8'd1;
    do_start();
`ifdef NORM_EARLY_ABORT_EN
    feed(N+1, "t2b");
`else
    feed(2*N, "t2b");
`endif
    wait_done("t2b");
    chk("t2b_accept",  {31'd0, accept}, 0);
    chk("t2b_norm_sq", {8'd0, norm_sq}, 16823);

    // Test 3: f[5]=-128 -> range reject even though the norm is small
    clear_coef();
    coef[5] = 8'h80;
    do_start();
`ifdef NORM_EARLY_ABORT_EN
    feed(6, "t3");
`else
    feed(2*N, "t3");
`endif
    wait_done("t3");
    chk("t3_accept",  {31'd0, accept}, 0);
    chk("t3_norm_sq", {8'd0, norm_sq}, 16384);
    read_chk("t3_rd_f5", 5, 8'h80);

    // Test 4: test-2 data with random idle cycles between coefficients
    load_test2();
    gaps = 1'b1;
    do_start();
    feed(2*N, "t4");
    gaps = 1'b0;
    wait_done("t4");
    chk("t4_accept",  {31'd0, accept}, 1);
    chk("t4_norm_sq", {8'd0, norm_sq}, 16822);

    // Test 5: reset halfway through g, then a clean test-1 run
    clear_coef();
    coef[0] = 8'd1;
    coef[N] = 8'd1;
    do_start();
    feed(N + N/2, "t5a");
    chk("t5_busy_before_rst", {31'd0, busy}, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_sampler_ena", {31'd0, sampler_ena}, 0);
    chk("t5_rst_busy",        {31'd0, busy}, 0);
    chk("t5_rst_accept",      {31'd0, accept}, 0);
    chk("t5_rst_norm_sq",     {8'd0, norm_sq}, 0);
    chk("t5_rst_done",        {31'd0, done}, 0);
    rst = 1'b0;
    tick();
    do_start();
    feed(2*N, "t5b");
    wait_done("t5b");
    chk("t5_accept",  {31'd0, accept}, 1);
    chk("t5_norm_sq", {8'd0, norm_sq}, 2);

`ifdef NORM_EARLY_ABORT_EN
    // Test 6: 127^2 + 127^2 = 32258 crosses the bound after two coefficients
    clear_coef();
    coef[0] = 8'd127;
    coef[1] = 8'd127;
    do_start();
    feed(2, "t6");
    chk("t6_ena_dropped", {31'd0, sampler_ena}, 0);
    wait_done("t6");
    chk("t6_accept",  {31'd0, accept}, 0);
    chk("t6_norm_sq", {8'd0, norm_sq}, 32258);
    f_valid = 1'b1;
    f       = 8'd55;
    repeat (4) tick();
    f_valid = 1'b0;
    chk("t6_ena_low",       {31'd0, sampler_ena}, 0);
    chk("t6_norm_sq_held",  {8'd0, norm_sq}, 32258);
    read_chk("t6_rd_f2_untouched", 2, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
